ram_march_tester: RTL and testbench

- Synthesizable initiator that drives the 4K x 16 RAM port (add, d_in, w, r, en) and checks d_out against expected data.
- Runs a 4-phase march: write pattern ascending, read/compare ascending, write inverse descending, read/compare descending.
- Reports pass/fail, first failing address and mismatch count.
- Sits between the top-level control/status and the RAM instance; it replaces bench-driven stimulus for self-test.

---
 rtl/ram_test_pkg.sv | 28 ++
 rtl/ram_march_tester_rd_cmp_pipe.sv | 59 +++++
 rtl/ram_march_tester.sv | 154 +++++++++++++++
 tb/tb_ram_march_tester.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared widths, pattern seed, FSM codes and expected-data helper
// for the RAM march tester.
package ram_test_pkg;

  localparam int          ADDR_W_DEF  = 12;
  localparam int          DATA_W_DEF  = 16;
  localparam logic [15:0] PATTERN_DEF = 16'hA5C3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_ASC = 3'd1;
  localparam logic [2:0] S_RD_ASC = 3'd2;
  localparam logic [2:0] S_DRAIN1 = 3'd3;
  localparam logic [2:0] S_WR_DSC = 3'd4;
  localparam logic [2:0] S_RD_DSC = 3'd5;
  localparam logic [2:0] S_DRAIN2 = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  function automatic logic [15:0] exp_data(
    input logic [15:0] pat,
    input logic [15:0] a,
    input logic        inv
  );
    logic [15:0] e;
    e = pat ^ a;
    return inv ? ~e : e;
  endfunction

endpackage

// File: rtl/ram_march_tester_rd_cmp_pipe.sv
// Read-compare pipeline: carries expected data and address alongside
// outstanding reads, flags a mismatch when the entry meets d_out.
module rd_cmp_pipe #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_exp,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              mism,
  output logic [ADDR_W-1:0] mism_addr
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] exp_q  [RD_LAT];
  logic [DATA_W-1:0] exp_d  [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      exp_d[i]  = exp_q[i];
      addr_d[i] = addr_q[i];
    end
    vld_d[0]  = push;
    exp_d[0]  = push_exp;
    addr_d[0] = push_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      exp_d[i]  = exp_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      exp_q  <= exp_d;
      addr_q <= addr_d;
    end
  end

  assign mism      = vld_q[RD_LAT-1] && (rd_data != exp_q[RD_LAT-1]);
  assign mism_addr = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_march_tester.sv
// 4-phase march self-test initiator for a single-port RAM.
// Define MARCH_STOP_ON_ERR_EN to abort on the first mismatch.
module ram_march_tester
  import ram_test_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          RD_LAT  = 1,
  parameter logic [15:0] PATTERN = PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_d_in,
  output logic              ram_w,
  output logic              ram_r,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_d_out
);

  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [1:0]        DC_LAST = 2'(RD_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              first_q, first_d;
  logic              pass_q, pass_d;

  logic              wr, rd, inv, flush, mism;
  logic [DATA_W-1:0] exp_w;
  logic [ADDR_W-1:0] mism_addr;

  assign wr    = (state_q == S_WR_ASC) || (state_q == S_WR_DSC);
  assign rd    = (state_q == S_RD_ASC) || (state_q == S_RD_DSC);
  assign inv   = (state_q == S_WR_DSC) || (state_q == S_RD_DSC);
  assign exp_w = DATA_W'(exp_data(PATTERN, 16'(add_q), inv));

  rd_cmp_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rd),
    .push_exp  (exp_w),
    .push_addr (add_q),
    .rd_data   (ram_d_out),
    .mism      (mism),
    .mism_addr (mism_addr)
  );

  always_comb begin
    state_d    = state_q;
    add_d      = add_q;
    dcnt_d     = dcnt_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    first_d    = first_q;
    pass_d     = pass_q;
    flush      = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_WR_ASC;
        add_d      = '0;
        err_cnt_d  = '0;
        err_addr_d = '0;
        first_d    = 1'b0;
        pass_d     = 1'b0;
      end
      S_WR_ASC: if (add_q == LAST) begin
        state_d = S_RD_ASC;
        add_d   = '0;
      end else add_d = add_q + ADDR_W'(1);
      S_RD_ASC: if (add_q == LAST) state_d = S_DRAIN1;
        else add_d = add_q + ADDR_W'(1);
      S_DRAIN1: if (dcnt_q == DC_LAST) begin
        state_d = S_WR_DSC;
        add_d   = LAST;
        dcnt_d  = '0;
      end else dcnt_d = dcnt_q + 2'd1;
      S_WR_DSC: if (add_q == '0) begin
        state_d = S_RD_DSC;
        add_d   = LAST;
      end else add_d = add_q - ADDR_W'(1);
      S_RD_DSC: if (add_q == '0) state_d = S_DRAIN2;
        else add_d = add_q - ADDR_W'(1);
      S_DRAIN2: if (dcnt_q == DC_LAST) begin
        state_d = S_FIN;
        dcnt_d  = '0;
      end else dcnt_d = dcnt_q + 2'd1;
      S_FIN: begin
        state_d = S_IDLE;
        add_d   = '0;
        pass_d  = (err_cnt_q == '0);
      end
      default: state_d = S_IDLE;
    endcase
    if (mism) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!first_q) begin
        err_addr_d = mism_addr;
        first_d    = 1'b1;
      end
`ifdef MARCH_STOP_ON_ERR_EN
      state_d = S_FIN;
      dcnt_d  = '0;
      flush   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      add_q      <= '0;
      dcnt_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      first_q    <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      add_q      <= add_d;
      dcnt_q     <= dcnt_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done     = (state_q == S_FIN);
  assign pass     = done ? (err_cnt_q == '0) : pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign ram_add  = add_q;
  assign ram_d_in = wr ? exp_w : '0;
  assign ram_w    = wr;
  assign ram_r    = wr | rd;
  assign ram_en   = wr | rd;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: faulty behavioural RAM, march-order
// reference model, random and directed fault runs.
module tb_ram_march_tester;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RL = 1;
  localparam int D  = 1 << AW;
  localparam int EXP_DONE = 4 * D + 2 * RL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, ram_w, ram_r, ram_en;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr, ram_add;
  logic [DW-1:0] ram_d_in, ram_d_out;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  ram_march_tester #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (RL),
    .PATTERN(16'hA5C3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr),
    .ram_add   (ram_add),
    .ram_d_in  (ram_d_in),
    .ram_w     (ram_w),
    .ram_r     (ram_r),
    .ram_en    (ram_en),
    .ram_d_out (ram_d_out)
  );

  logic [15:0] mem [D];
  logic [15:0] sa1 [D];
  logic [15:0] sa0 [D];

  // RAM with one-cycle registered read and stuck-at faults on read
  always @(posedge clk) begin
    if (ram_en && ram_w) mem[ram_add] <= ram_d_in;
    if (ram_en && !ram_w)
      ram_d_out <= (mem[ram_add] | sa1[ram_add]) & ~sa0[ram_add];
  end

  typedef struct packed {
    logic          w;
    logic          r;
    logic [AW-1:0] a;
    logic [15:0]   d;
  } acc_t;

  acc_t log_q[$];
  bit   log_on = 1'b0;

  always @(posedge clk) begin
    if (log_on && rst_n && ram_en)
      log_q.push_back({ram_w, ram_r, ram_add, ram_d_in});
    if (rst_n && done) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] e_of(input int a, input bit inv);
    logic [15:0] v;
    v = 16'hA5C3 ^ 16'(a);
    return inv ? ~v : v;
  endfunction

  function automatic void clear_faults();
    for (int a = 0; a < D; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endfunction

  // Expected error count and first failing address in march read order
  function automatic void model(output int cnt, output int faddr);
    int a;
    logic [15:0] e, got;
    bit found;
    cnt = 0;
    faddr = 0;
    found = 0;
    for (int k = 0; k < 2 * D; k++) begin
      a = (k < D) ? k : (2 * D - 1 - k);
      e = e_of(a, k >= D);
      got = (e | sa1[a]) & ~sa0[a];
      if (got != e) begin
        cnt++;
        if (!found) faddr = a;
        found = 1;
      end
    end
  endfunction

  task automatic run_march(input string tag, input bit noisy);
    int n, ecnt, eaddr, bad_log, k, a;
    bit busy_gap, w;
    model(ecnt, eaddr);
    log_q.delete();
    log_on = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_gap = 0;
    while (!done && n < 4 * EXP_DONE) begin
      if (!busy) busy_gap = 1;
      start = noisy && ($urandom_range(0, 2) == 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_run"}, 32'(busy_gap), 0);
    chk({tag, "_busy_fin"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 32'(ecnt == 0));
    chk({tag, "_err_addr"}, 32'(err_addr), eaddr);
`ifdef MARCH_STOP_ON_ERR_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), (ecnt > 0) ? 1 : 0);
    if (ecnt > 0) chk({tag, "_stop_lat"}, 32'(n < EXP_DONE), 1);
    else chk({tag, "_done_lat"}, n, EXP_DONE);
`else
    chk({tag, "_err_cnt"}, 32'(err_cnt), ecnt);
    chk({tag, "_done_lat"}, n, EXP_DONE);
    bad_log = 0;
    k = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < D; i++) begin
        a = (ph < 2) ? i : D - 1 - i;
        w = (ph % 2) == 0;
        if (k >= log_q.size()) bad_log++;
        else if (log_q[k].w !== w || log_q[k].r !== 1'b1 ||
                 log_q[k].a !== AW'(a) ||
                 (w && log_q[k].d !== e_of(a, ph >= 2)))
          bad_log++;
        k++;
      end
    end
    chk({tag, "_log_len"}, log_q.size(), 4 * D);
    chk({tag, "_log_seq"}, bad_log, 0);
    chk({tag, "_d_in_at_2"}, 32'(log_q[2].d), 32'h0000A5C1);
`endif
    log_on = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_pass_hold"}, 32'(pass), 32'(ecnt == 0));
  endtask

  initial begin
    int n, dseen, na;
    for (int a = 0; a < D; a++) mem[a] = '0;
    clear_faults();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_en", 32'({ram_en, ram_r, ram_w}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_err_addr", 32'(err_addr), 0);
    chk("rst_add", 32'(ram_add), 0);
    chk("rst_d_in", 32'(ram_d_in), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_march("clean", 0);

    sa1[5] = 16'h0008;
    run_march("sa1_a5", 0);

    clear_faults();
    sa1[9] = 16'h0008;
    sa1[3] = 16'h0008;
    run_march("two_faults", 0);

    clear_faults();
    run_march("restart_ignored", 1);

    for (int r = 0; r < 4; r++) begin
      clear_faults();
      na = $urandom_range(1, 3);
      for (int f = 0; f < na; f++) begin
        n = $urandom_range(0, D - 1);
        if ($urandom_range(0, 1) == 1)
          sa1[n] = sa1[n] | 16'(1 << $urandom_range(0, 15));
        else
          sa0[n] = sa0[n] | 16'(1 << $urandom_range(0, 15));
        sa0[n] = sa0[n] & ~sa1[n];
      end
      run_march($sformatf("rand%0d", r), r[0]);
    end

    clear_faults();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(ram_en && !ram_w) && n < 4 * EXP_DONE) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_rd", 32'(ram_en && !ram_w), 1);
    repeat (3) @(negedge clk);
    dseen = done_seen;
    rst_n = 1'b0;
    #1;
    chk("abort_en", 32'({ram_en, ram_r, ram_w}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * EXP_DONE) @(negedge clk);
    chk("abort_no_done", done_seen - dseen, 0);
    chk("abort_idle", 32'(busy), 0);
    run_march("after_abort", 0);

    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!done && n < 4 * EXP_DONE) begin
      @(negedge clk);
      n++;
    end
    chk("held_done", 32'(done), 1);
    @(negedge clk);
    chk("held_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("held_restart", 32'(busy), 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 4 * EXP_DONE) begin
      @(negedge clk);
      n++;
    end
    chk("held_done2", 32'(done), 1);
    chk("held_pass2", 32'(pass), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
